pdm_record_controller: RTL and testbench

- Sequences the PDM deserializer for record and playback of 16-bit words.
- Record: enables the deserializer, captures each completed word and writes it to a single-port sample memory at an incrementing address.
- Playback: reads the stored words back at the sample rate and presents them to the audio output stage.
- Owns the sample-memory port exclusively; sits between the top-level button controller, the deserializer and the sample RAM.

---
 rtl/pdm_record_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_pdm_record_controller.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_record_controller.sv
// -----------------------------------------------------------------------------
// pdm_record_controller
//
// Controls recording and playback of 16-bit PDM deserializer words through a
// single-port sample RAM. This block is the only user of the RAM port.
//
// Recording: the deserializer is enabled and each finished word is written
// one cycle after its done pulse, at addresses 0, 1, 2, ... Recording stops on
// stop_i, or by itself after the last address has been written.
//
// Playback: one stored word is read every PLAY_PERIOD+1 cycles and shown on
// play_data_o, with a one-cycle play_valid_o pulse.
//
// Optional feature (compile-time macro PDM_RECORD_LOOP_PLAYBACK_EN):
//   defined     - playback wraps to address 0 after the last word and keeps
//                 running until stop_i or reset.
//   not defined - playback returns to IDLE after one pass.
//
// Ports:
//   clock_i         in   system clock (100 MHz)
//   reset_n_i       in   asynchronous active-low reset
//   record_start_i  in   pulse: start recording (takes priority over play)
//   play_start_i    in   pulse: start playback (ignored when length_o == 0)
//   stop_i          in   pulse: end recording / playback
//   deser_enable_o  out  deserializer enable (low holds it in reset)
//   deser_done_i    in   pulse: deserializer word ready
//   deser_data_i    in   deserializer word, valid with deser_done_i
//   mem_addr_o      out  sample RAM address
//   mem_wdata_o     out  sample RAM write data
//   mem_we_o        out  sample RAM write enable
//   mem_rdata_i     in   sample RAM read data (1-cycle read latency)
//   play_data_o     out  current playback word
//   play_valid_o    out  pulse: play_data_o carries a new word
//   length_o        out  word count of the last completed recording
//   busy_o          out  recording or playing
// -----------------------------------------------------------------------------
module pdm_record_controller #(
  parameter int ADDR_WIDTH  = 17,
  parameter int WORD_LENGTH = 16,
  parameter int PLAY_PERIOD = 1600
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   record_start_i,
  input  logic                   play_start_i,
  input  logic                   stop_i,
  output logic                   deser_enable_o,
  input  logic                   deser_done_i,
  input  logic [WORD_LENGTH-1:0] deser_data_i,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [WORD_LENGTH-1:0] mem_wdata_o,
  output logic                   mem_we_o,
  input  logic [WORD_LENGTH-1:0] mem_rdata_i,
  output logic [WORD_LENGTH-1:0] play_data_o,
  output logic                   play_valid_o,
  output logic [ADDR_WIDTH:0]    length_o,
  output logic                   busy_o
);

  localparam int CNT_WIDTH = (PLAY_PERIOD > 1) ? $clog2(PLAY_PERIOD) : 1;

  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(PLAY_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    PLAY,
    READ_WAIT
  } state_t;

  state_t                 state_reg, state_next;
  // Write pointer is one bit wider than the address so a full memory can be
  // counted as 2**ADDR_WIDTH words.
  logic [ADDR_WIDTH:0]    wptr_reg, wptr_next;
  logic [ADDR_WIDTH-1:0]  rptr_reg, rptr_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [ADDR_WIDTH:0]    length_reg, length_next;
  logic [WORD_LENGTH-1:0] wdata_reg, wdata_next;
  logic [WORD_LENGTH-1:0] play_data_reg, play_data_next;
  logic                   wr_pending_reg, wr_pending_next;
  logic                   stop_pending_reg, stop_pending_next;
  logic                   enable_reg, enable_next;

  logic                   write_now;
  logic                   last_write;
  logic                   capture;
  logic                   last_read;
  logic [ADDR_WIDTH:0]    wptr_inc;

  // A captured word is written in the cycle after its done pulse.
  assign write_now  = (state_reg == RECORD) && wr_pending_reg;
  assign last_write = write_now && (wptr_reg[ADDR_WIDTH-1:0] == ADDR_LAST);
  // Once the last address is being written, any further word is dropped so
  // the recording never wraps around onto address 0.
  assign capture    = (state_reg == RECORD) && enable_reg && deser_done_i && !last_write;
  assign wptr_inc   = wptr_reg + LEN_ONE;
  assign last_read  = ({1'b0, rptr_reg} == (length_reg - LEN_ONE));

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg        <= IDLE;
      wptr_reg         <= '0;
      rptr_reg         <= '0;
      cnt_reg          <= '0;
      length_reg       <= '0;
      wdata_reg        <= '0;
      play_data_reg    <= '0;
      wr_pending_reg   <= 1'b0;
      stop_pending_reg <= 1'b0;
      enable_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      wptr_reg         <= wptr_next;
      rptr_reg         <= rptr_next;
      cnt_reg          <= cnt_next;
      length_reg       <= length_next;
      wdata_reg        <= wdata_next;
      play_data_reg    <= play_data_next;
      wr_pending_reg   <= wr_pending_next;
      stop_pending_reg <= stop_pending_next;
      enable_reg       <= enable_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    wptr_next         = wptr_reg;
    rptr_next         = rptr_reg;
    cnt_next          = cnt_reg;
    length_next       = length_reg;
    wdata_next        = wdata_reg;
    play_data_next    = play_data_reg;
    wr_pending_next   = 1'b0;
    stop_pending_next = 1'b0;
    enable_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (record_start_i) begin
          state_next  = RECORD;
          wptr_next   = '0;
          enable_next = 1'b1;
        end else if (play_start_i && (length_reg != '0)) begin
          state_next = PLAY;
          rptr_next  = '0;
          cnt_next   = '0;
        end
      end

      RECORD: begin
        enable_next       = enable_reg;
        stop_pending_next = stop_pending_reg;
        if (write_now) begin
          wptr_next = wptr_inc;
        end
        if (capture) begin
          wr_pending_next = 1'b1;
          wdata_next      = deser_data_i;
        end

        if (last_write) begin
          state_next        = IDLE;
          enable_next       = 1'b0;
          wr_pending_next   = 1'b0;
          stop_pending_next = 1'b0;
          length_next       = DEPTH;
        end else if (stop_pending_reg) begin
          // Final write of a word that arrived together with stop_i.
          state_next        = IDLE;
          stop_pending_next = 1'b0;
          length_next       = write_now ? wptr_inc : wptr_reg;
        end else if (stop_i) begin
          // The deserializer is switched off right away; if a word arrived
          // with the stop, stay one more cycle so it is still written.
          enable_next = 1'b0;
          if (capture) begin
            stop_pending_next = 1'b1;
          end else begin
            state_next  = IDLE;
            length_next = write_now ? wptr_inc : wptr_reg;
          end
        end
      end

      PLAY: begin
        if (stop_i) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = READ_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      READ_WAIT: begin
        play_data_next = mem_rdata_i;
        if (stop_i) begin
          state_next = IDLE;
        end else if (last_read) begin
`ifdef PDM_RECORD_LOOP_PLAYBACK_EN
          rptr_next  = '0;
          state_next = PLAY;
`else
          state_next = IDLE;
`endif
        end else begin
          rptr_next  = rptr_reg + ADDR_ONE;
          state_next = PLAY;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign deser_enable_o = enable_reg;
  assign mem_we_o       = write_now;
  assign mem_wdata_o    = wdata_reg;
  assign length_o       = length_reg;
  assign busy_o         = (state_reg != IDLE);

  // The RAM has the read address during the whole PLAY phase, so its data is
  // ready in READ_WAIT and is passed straight through in that cycle.
  assign play_valid_o   = (state_reg == READ_WAIT);
  assign play_data_o    = (state_reg == READ_WAIT) ? mem_rdata_i : play_data_reg;

  always_comb begin
    mem_addr_o = '0;
    case (state_reg)
      RECORD:          mem_addr_o = wptr_reg[ADDR_WIDTH-1:0];
      PLAY, READ_WAIT: mem_addr_o = rptr_reg;
      default:         mem_addr_o = '0;
    endcase
  end

endmodule

// File: tb/tb_pdm_record_controller.sv
// -----------------------------------------------------------------------------
// tb_pdm_record_controller
//
// Directed test of pdm_record_controller with a small memory (ADDR_WIDTH = 4)
// and a short playback period (PLAY_PERIOD = 4). A behavioural sample RAM is
// connected to the controller. Expected RAM writes and playback words are
// pushed to queues when the stimulus is driven. Negedge monitors pop the
// queues and compare each entry, including the cycle it should appear in.
// -----------------------------------------------------------------------------
module tb_pdm_record_controller;

  localparam int AW = 4;
  localparam int WL = 16;
  localparam int PP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          record_start;
  logic          play_start;
  logic          stop;
  logic          deser_enable;
  logic          deser_done;
  logic [WL-1:0] deser_data;
  logic [AW-1:0] mem_addr;
  logic [WL-1:0] mem_wdata;
  logic          mem_we;
  logic [WL-1:0] mem_rdata;
  logic [WL-1:0] play_data;
  logic          play_valid;
  logic [AW:0]   length;
  logic          busy;

  always #5 clk = ~clk;

  pdm_record_controller #(
    .ADDR_WIDTH (AW),
    .WORD_LENGTH(WL),
    .PLAY_PERIOD(PP)
  ) dut (
    .clock_i       (clk),
    .reset_n_i     (rst_n),
    .record_start_i(record_start),
    .play_start_i  (play_start),
    .stop_i        (stop),
    .deser_enable_o(deser_enable),
    .deser_done_i  (deser_done),
    .deser_data_i  (deser_data),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_we_o      (mem_we),
    .mem_rdata_i   (mem_rdata),
    .play_data_o   (play_data),
    .play_valid_o  (play_valid),
    .length_o      (length),
    .busy_o        (busy)
  );

  // Behavioural single-port sample RAM with a registered read.
  logic [WL-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [WL-1:0] data;
  } exp_t;

  exp_t wq[$];
  exp_t pq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_deser_enable"}, 32'(deser_enable), 32'd0);
    check({tag, "_mem_addr"},     32'(mem_addr),     32'd0);
    check({tag, "_mem_wdata"},    32'(mem_wdata),    32'd0);
    check({tag, "_mem_we"},       32'(mem_we),       32'd0);
    check({tag, "_play_data"},    32'(play_data),    32'd0);
    check({tag, "_play_valid"},   32'(play_valid),   32'd0);
    check({tag, "_length"},       32'(length),       32'd0);
    check({tag, "_busy"},         32'(busy),         32'd0);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read on the
  // falling edge of the same cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One-cycle done pulse; expects the write one cycle later at addr.
  task automatic done_pulse(input logic [WL-1:0] d, input logic [AW-1:0] addr, input bit expect_write);
    exp_t e;
    tick();
    deser_done = 1'b1;
    deser_data = d;
    if (expect_write) begin
      e.cyc  = cyc + 1;
      e.addr = addr;
      e.data = d;
      wq.push_back(e);
    end
    tick();
    deser_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = wq.pop_front();
        $display("[TB] write  cycle %0d addr %0d data 0x%04h", cyc, mem_addr, mem_wdata);
        check("wr_cycle", 32'(cyc),       32'(e.cyc));
        check("wr_addr",  32'(mem_addr),  32'(e.addr));
        check("wr_data",  32'(mem_wdata), 32'(e.data));
      end
    end
    if (rst_n === 1'b1 && play_valid === 1'b1) begin
      if (pq.size() == 0) begin
        check("unexpected_play", 32'(play_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = pq.pop_front();
        $display("[TB] play   cycle %0d data 0x%04h", cyc, play_data);
        check("play_cycle", 32'(cyc),       32'(e.cyc));
        check("play_data",  32'(play_data), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [WL-1:0] rec_words [3];
  int   s;
  exp_t pe;

  initial begin
    rst_n        = 1'b0;
    record_start = 1'b0;
    play_start   = 1'b0;
    stop         = 1'b0;
    deser_done   = 1'b0;
    deser_data   = '0;
    rec_words[0] = 16'h1234;
    rec_words[1] = 16'hABCD;
    rec_words[2] = 16'h0001;

    // Reset state.
    #2;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    sample();
    check_all_zero("idle");

    // Playback request with nothing recorded is ignored.
    tick();
    play_start = 1'b1;
    tick();
    play_start = 1'b0;
    sample();
    check("play_len0_busy", 32'(busy), 32'd0);

    // Record three words, then stop.
    tick();
    record_start = 1'b1;
    tick();
    record_start = 1'b0;
    sample();
    check("rec_enable", 32'(deser_enable), 32'd1);
    check("rec_busy",   32'(busy),         32'd1);
    for (int i = 0; i < 3; i++) done_pulse(rec_words[i], AW'(i), 1'b1);
    tick();
    stop = 1'b1;
    sample();
    check("rec_enable_at_stop", 32'(deser_enable), 32'd1);
    tick();
    stop = 1'b0;
    sample();
    check("rec_enable_after_stop", 32'(deser_enable), 32'd0);
    check("rec_busy_after_stop",   32'(busy),         32'd0);
    check("rec_length",            32'(length),       32'd3);

    // Playback: a word every PP+1 cycles, first one PP+1 cycles after start.
    tick();
    play_start = 1'b1;
    s = cyc;
    for (int i = 0; i < 3; i++) begin
      pe.cyc  = s + (i + 1) * (PP + 1);
      pe.addr = AW'(i);
      pe.data = rec_words[i];
      pq.push_back(pe);
    end
`ifdef PDM_RECORD_LOOP_PLAYBACK_EN
    pe.cyc  = s + 4 * (PP + 1);
    pe.addr = '0;
    pe.data = rec_words[0];
    pq.push_back(pe);
`endif
    tick();
    play_start = 1'b0;
    sample();
    check("play_busy", 32'(busy), 32'd1);
`ifdef PDM_RECORD_LOOP_PLAYBACK_EN
    while (cyc < s + 4 * (PP + 1) + 1) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    sample();
    check("play_busy_end",   32'(busy),      32'd0);
    check("play_data_hold",  32'(play_data), 32'h1234);
`else
    while (cyc < s + 3 * (PP + 1) + 1) tick();
    sample();
    check("play_busy_end",   32'(busy),      32'd0);
    check("play_data_hold",  32'(play_data), 32'h0001);
`endif
    check("play_queue_empty", 32'(pq.size()), 32'd0);

    // Record and play requested together: record wins. Then a word arrives
    // in the same cycle as stop and must still be written and counted.
    tick();
    record_start = 1'b1;
    play_start   = 1'b1;
    tick();
    record_start = 1'b0;
    play_start   = 1'b0;
    sample();
    check("rec_wins_enable", 32'(deser_enable), 32'd1);
    check("rec_wins_addr",   32'(mem_addr),     32'd0);
    done_pulse(16'h1111, AW'(0), 1'b1);
    done_pulse(16'h2222, AW'(1), 1'b1);
    tick();
    deser_done = 1'b1;
    deser_data = 16'h5555;
    stop       = 1'b1;
    pe.cyc  = cyc + 1;
    pe.addr = AW'(2);
    pe.data = 16'h5555;
    wq.push_back(pe);
    tick();
    deser_done = 1'b0;
    stop       = 1'b0;
    sample();
    check("stopdone_enable", 32'(deser_enable), 32'd0);
    tick();
    sample();
    check("stopdone_busy",   32'(busy),   32'd0);
    check("stopdone_length", 32'(length), 32'd3);

    // Fill the whole memory with back-to-back words; stops by itself.
    tick();
    record_start = 1'b1;
    tick();
    record_start = 1'b0;
    for (int i = 0; i < 2**AW; i++) begin
      if (i != 0) tick();
      deser_done = 1'b1;
      deser_data = WL'(i);
      pe.cyc  = cyc + 1;
      pe.addr = AW'(i);
      pe.data = WL'(i);
      wq.push_back(pe);
    end
    tick();
    deser_done = 1'b0;
    tick();
    sample();
    check("full_busy",   32'(busy),         32'd0);
    check("full_enable", 32'(deser_enable), 32'd0);
    check("full_length", 32'(length),       32'(2**AW));
    done_pulse(16'h0010, AW'(0), 1'b0);
    tick();
    tick();
    sample();
    check("full_no_extra_write", 32'(wq.size()), 32'd0);
    check("full_length_hold",    32'(length),    32'(2**AW));

    // Reset in the middle of a recording discards it.
    tick();
    record_start = 1'b1;
    tick();
    record_start = 1'b0;
    for (int i = 0; i < 5; i++) done_pulse(WL'(16'h0100 + i), AW'(i), 1'b1);
    tick();
    sample();
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    sample();
    check("post_reset_length", 32'(length), 32'd0);
    check("post_reset_busy",   32'(busy),   32'd0);
    check("write_queue_empty", 32'(wq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
